dot_product_accumulator: RTL and testbench

Downstream consumer of `unsigned_multiplier`. Sequences the multiplier through N_TERMS products, accumulates each product on its `finish` pulse, and presents the final sum through a valid/ready output handshake. Together with the multiplier, it forms a small dot-product (MAC) datapath. The accumulator saturates, and a sticky overflow flag reports any saturation.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/sat_adder.sv | 19 +
 rtl/dot_product_accumulator.sv | 93 +++++++++
 tb/tb_dot_product_accumulator.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state type, default widths and sizing helper for the MAC datapath
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// rtl/sat_adder.sv - combinational saturating adder; carry flags a clamped result
module sat_adder import mac_pkg::*; #(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         carry
);

  logic [W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + {1'b0, b};
    carry = raw[W];
    sum   = raw[W] ? '1 : raw[W-1:0];
  end

endmodule

// File: rtl/dot_product_accumulator.sv
// rtl/dot_product_accumulator.sv - sequences N_TERMS multiplier runs and accumulates a saturating sum
module dot_product_accumulator import mac_pkg::*; #(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int N_TERMS = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int CNT_W   = clog2(N_TERMS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              go,
  input  logic              finish,
  input  logic [PROD_W-1:0] product,
  output logic              mul_start,
  output logic [CNT_W-1:0]  term_cnt,
  output logic              busy,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic              overflow
);

  state_t           state;
  state_t           next_state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] product_ext;
  logic             acc_carry;
  logic             last_term;

  assign product_ext = ACC_W'(product);
  assign last_term   = (term_cnt == CNT_W'(N_TERMS - 1));

  sat_adder #(.W(ACC_W)) u_sat_adder (
    .a     (acc),
    .b     (product_ext),
    .sum   (acc_sum),
    .carry (acc_carry)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: if (go) next_state = REQ;
        REQ:  next_state = WAIT;
        WAIT: if (finish) next_state = last_term ? DONE : REQ;
        DONE: if (sum_ready) next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs decode from state only; finish/product/sum_ready never reach a port combinationally.
  always_comb begin
    mul_start = 1'b0;
    busy      = 1'b0;
    sum_valid = 1'b0;
    case (state)
      REQ:  begin mul_start = 1'b1; busy = 1'b1; end
      WAIT: busy = 1'b1;
      DONE: sum_valid = 1'b1;
      default: ;
    endcase
  end

  // acc is frozen outside WAIT, so sum_out is stable for the whole DONE handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      term_cnt <= '0;
      overflow <= 1'b0;
    end else if (clear || (state == IDLE && go)) begin
      acc      <= '0;
      term_cnt <= '0;
      overflow <= 1'b0;
    end else if (state == WAIT && finish) begin
      acc      <= acc_sum;
      term_cnt <= term_cnt + 1'b1;
      if (acc_carry) overflow <= 1'b1;
    end
  end

  assign sum_out = acc;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// tb/tb_dot_product_accumulator.sv - scoreboard bench for dot_product_accumulator (10-bit and 8-bit accumulators)
module tb_dot_product_accumulator;

  localparam int N_TERMS = 4;
  localparam int CNT_W   = 2;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       go;
  logic       finish;
  logic       sum_ready;
  logic [7:0] product;

  logic       mul_start_a, busy_a, sum_valid_a, overflow_a;
  logic [1:0] term_cnt_a;
  logic [9:0] sum_out_a;
  logic       mul_start_b, busy_b, sum_valid_b, overflow_b;
  logic [1:0] term_cnt_b;
  logic [7:0] sum_out_b;

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int last_s10 = 0;

  typedef struct {
    int s10;
    int o10;
    int s8;
    int o8;
  } exp_t;
  exp_t sb[$];

  dot_product_accumulator #(.PROD_W(8), .N_TERMS(N_TERMS), .ACC_W(10)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .go(go), .finish(finish), .product(product),
    .mul_start(mul_start_a), .term_cnt(term_cnt_a), .busy(busy_a), .sum_out(sum_out_a),
    .sum_valid(sum_valid_a), .sum_ready(sum_ready), .overflow(overflow_a)
  );

  dot_product_accumulator #(.PROD_W(8), .N_TERMS(N_TERMS), .ACC_W(8)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .go(go), .finish(finish), .product(product),
    .mul_start(mul_start_b), .term_cnt(term_cnt_b), .busy(busy_b), .sum_out(sum_out_b),
    .sum_valid(sum_valid_b), .sum_ready(sum_ready), .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int t, input int w);
    return (t >= (1 << w)) ? (1 << w) - 1 : t;
  endfunction

  task automatic push_exp(input int p[4]);
    exp_t e;
    int t;
    t = 0;
    for (int i = 0; i < 4; i++) t += p[i];
    e.s10 = clamp(t, 10);
    e.o10 = (t >= 1024) ? 1 : 0;
    e.s8  = clamp(t, 8);
    e.o8  = (t >= 256) ? 1 : 0;
    sb.push_back(e);
    last_s10 = e.s10;
  endtask

  task automatic check_reset_vals();
    chk("rst_mul_start_a", int'(mul_start_a), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_valid_a", int'(sum_valid_a), 0);
    chk("rst_ovf_a", int'(overflow_a), 0);
    chk("rst_cnt_a", int'(term_cnt_a), 0);
    chk("rst_sum_a", int'(sum_out_a), 0);
    chk("rst_mul_start_b", int'(mul_start_b), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_valid_b", int'(sum_valid_b), 0);
    chk("rst_ovf_b", int'(overflow_b), 0);
    chk("rst_cnt_b", int'(term_cnt_b), 0);
    chk("rst_sum_b", int'(sum_out_b), 0);
  endtask

  task automatic wait_mul_start();
    int t;
    t = 0;
    while (!mul_start_a && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mul_start_seen", int'(mul_start_a), 1);
  endtask

  task automatic drive_go();
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    chk("go_busy", int'(busy_a), 1);
    chk("go_cnt", int'(term_cnt_a), 0);
    chk("go_acc", int'(sum_out_a), 0);
    chk("go_ovf_a", int'(overflow_a), 0);
    chk("go_ovf_b", int'(overflow_b), 0);
  endtask

  // Plays the multiplier: answers a start pulse after lat idle WAIT cycles.
  task automatic do_term(input int p, input int lat, input bit hold);
    wait_mul_start();
    @(posedge clk); #1;
    finish = 1'b0;
    repeat (lat) begin
      @(posedge clk); #1;
    end
    finish  = 1'b1;
    product = 8'(p);
    @(posedge clk); #1;
    if (!hold) finish = 1'b0;
  endtask

  task automatic run_seq(input int p[4], input int bp, input bit rnd);
    int n0;
    int t;
    int lat;
    bit hold;
    push_exp(p);
    sum_ready = (bp == 0);
    n0 = n_start;
    drive_go();
    for (int i = 0; i < N_TERMS; i++) begin
      lat  = rnd ? int'($urandom_range(0, 3)) : 0;
      hold = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      do_term(p[i], lat, hold);
    end
    chk("done_cnt", int'(term_cnt_a), N_TERMS % (1 << CNT_W));
    repeat (bp) begin
      @(posedge clk); #1;
      finish = 1'b0;
    end
    sum_ready = 1'b1;
    t = 0;
    while (sum_valid_a && t < 10) begin
      @(posedge clk); #1;
      finish = 1'b0;
      t++;
    end
    finish = 1'b0;
    chk("xfer_done", int'(sum_valid_a), 0);
    chk("mul_start_pulses", n_start - n0, N_TERMS);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (mul_start_a) n_start++;
      if (sum_valid_a) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", int'(sum_valid_a), 0);
        end else begin
          chk("sum_a", int'(sum_out_a), sb[0].s10);
          chk("ovf_a", int'(overflow_a), sb[0].o10);
          chk("sum_b", int'(sum_out_b), sb[0].s8);
          chk("ovf_b", int'(overflow_b), sb[0].o8);
          chk("valid_b", int'(sum_valid_b), 1);
          if (sum_ready) void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    int p[4];
    reset = 1'b1; clear = 1'b0; go = 1'b0; finish = 1'b0; sum_ready = 1'b0; product = '0;
    #1 reset = 1'b0;
    #2;
    check_reset_vals();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // reset while waiting on the third product
    drive_go();
    do_term(3, 0, 1'b0);
    do_term(4, 1, 1'b0);
    wait_mul_start();
    @(posedge clk); #1;
    chk("midwait_busy", int'(busy_a), 1);
    chk("midwait_cnt", int'(term_cnt_a), 2);
    chk("midwait_sum", int'(sum_out_a), 7);
    #2 reset = 1'b0;
    #1;
    check_reset_vals();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_seq('{1, 18, 126, 35}, 0, 1'b0);
    run_seq('{1, 18, 126, 35}, 5, 1'b0);
    run_seq('{225, 225, 105, 15}, 0, 1'b1);
    run_seq('{225, 225, 225, 225}, 0, 1'b0);
    run_seq('{255, 0, 0, 0}, 2, 1'b1);
    run_seq('{255, 1, 0, 0}, 0, 1'b1);

    // finish while idle must not disturb the held result
    finish = 1'b1;
    product = 8'd99;
    repeat (2) begin
      @(posedge clk); #1;
    end
    finish = 1'b0;
    chk("idle_sum", int'(sum_out_a), last_s10);
    chk("idle_cnt", int'(term_cnt_a), 0);
    chk("idle_busy", int'(busy_a), 0);

    // clear collides with finish in WAIT
    drive_go();
    do_term(255, 0, 1'b0);
    do_term(10, 2, 1'b0);
    wait_mul_start();
    @(posedge clk); #1;
    finish = 1'b1;
    product = 8'd77;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    finish = 1'b0;
    chk("clr_sum_a", int'(sum_out_a), 0);
    chk("clr_sum_b", int'(sum_out_b), 0);
    chk("clr_cnt", int'(term_cnt_a), 0);
    chk("clr_busy", int'(busy_a), 0);
    chk("clr_valid", int'(sum_valid_a), 0);
    chk("clr_ovf_b", int'(overflow_b), 0);
    @(posedge clk); #1;
    chk("clr_idle_start", int'(mul_start_a), 0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) p[i] = int'($urandom_range(0, 15)) * int'($urandom_range(0, 15));
      run_seq(p, int'($urandom_range(0, 3)), 1'b1);
    end

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
